// File: rtl/seq_reduce_pkg.sv
// Shared types and helpers for the chunked bit-reduction engine.
// Holds the FSM state encoding, mode codes and per-mode identity.
package seq_reduce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [1:0] MODE_AND  = 2'b00;
    localparam logic [1:0] MODE_OR   = 2'b01;
    localparam logic [1:0] MODE_XOR  = 2'b10;
    localparam logic [1:0] MODE_NAND = 2'b11;

    // Neutral element of the accumulating op; NAND accumulates as AND.
    function automatic logic identity(input logic [1:0] m);
        return (m == MODE_AND) || (m == MODE_NAND);
    endfunction

endpackage

// File: rtl/reduce_chunk.sv
// Combinational reduction of one chunk by mode.
// Bits outside the operand are replaced with the mode identity.
module reduce_chunk
    import seq_reduce_pkg::*;
#(
    parameter int CHUNK_WIDTH = 2
) (
    input  logic [CHUNK_WIDTH-1:0] chunk_i,
    input  logic [CHUNK_WIDTH-1:0] mask_i,
    input  logic [1:0]             mode_i,
    output logic                   red_o
);

    logic [CHUNK_WIDTH-1:0] padded;

    always_comb begin
        padded = '0;
        for (int j = 0; j < CHUNK_WIDTH; j++) begin
            padded[j] = mask_i[j] ? chunk_i[j] : identity(mode_i);
        end
    end

    always_comb begin
        red_o = 1'b0;
        case (mode_i)
            MODE_OR:  red_o = |padded;
            MODE_XOR: red_o = ^padded;
            default:  red_o = &padded;
        endcase
    end

endmodule

// File: rtl/seq_reduce.sv
// Multi-cycle reduction (AND/OR/XOR/NAND) of an operand, CHUNK_WIDTH
// bits per cycle, with early exit for AND/NAND/OR and supply gating.
module seq_reduce
    import seq_reduce_pkg::*;
#(
    parameter int INPUT_WIDTH = 8,
    parameter int CHUNK_WIDTH = 2
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [1:0]             DigitSupply,
    input  logic                   inputValid,
    output logic                   inputReady,
    input  logic [INPUT_WIDTH-1:0] inputData,
    input  logic [1:0]             mode,
    output logic                   outputValid,
    input  logic                   outputReady,
    output logic                   outputData,
    output logic                   busy
);

    localparam int NUM_CHUNKS = (INPUT_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
    localparam int CNT_W      = $clog2(NUM_CHUNKS) + 1;
    localparam int PAD_W      = NUM_CHUNKS * CHUNK_WIDTH;

    state_e                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] data_q, data_d;
    logic [1:0]             mode_q, mode_d;
    logic                   acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   powered;
    logic [PAD_W-1:0]       data_pad;
    logic [PAD_W-1:0]       data_sh;
    logic [CHUNK_WIDTH-1:0] chunk;
    logic [CHUNK_WIDTH-1:0] mask;
    logic                   red;
    logic                   last;
    logic                   hit;

    assign powered  = (DigitSupply == 2'b10);
    assign data_pad = PAD_W'(data_q);
    assign data_sh  = data_pad >> (int'(cnt_q) * CHUNK_WIDTH);
    assign chunk    = data_sh[CHUNK_WIDTH-1:0];
    assign last     = (cnt_q == CNT_W'(NUM_CHUNKS - 1));

    always_comb begin
        mask = '0;
        for (int j = 0; j < CHUNK_WIDTH; j++) begin
            mask[j] = (int'(cnt_q) * CHUNK_WIDTH + j) < INPUT_WIDTH;
        end
    end

    reduce_chunk #(
        .CHUNK_WIDTH(CHUNK_WIDTH)
    ) u_reduce_chunk (
        .chunk_i(chunk),
        .mask_i (mask),
        .mode_i (mode_q),
        .red_o  (red)
    );

    // A chunk that already decides the result ends the run early.
    always_comb begin
        hit = 1'b0;
        case (mode_q)
            MODE_OR:  hit = red;
            MODE_XOR: hit = 1'b0;
            default:  hit = !red;
        endcase
    end

    assign inputReady  = powered && (state_q == ST_IDLE);
    assign outputValid = powered && (state_q == ST_DONE);
    assign outputData  = outputValid && (acc_q ^ (mode_q == MODE_NAND));
    assign busy        = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (inputValid && inputReady) begin
                    data_d  = inputData;
                    mode_d  = mode;
                    acc_d   = identity(mode);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                case (mode_q)
                    MODE_OR:  acc_d = acc_q | red;
                    MODE_XOR: acc_d = acc_q ^ red;
                    default:  acc_d = acc_q & red;
                endcase
                cnt_d = cnt_q + 1'b1;
                if (last || hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (outputReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset || !powered) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            mode_q  <= MODE_AND;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/seq_reduce.md
SEQ_REDUCE -- requirements
Module: seq_reduce

Interface
REQ-001 Parameter INPUT_WIDTH, default 8, number of operand bits, legal range >= 1.
REQ-002 Parameter CHUNK_WIDTH, default 2, bits consumed per cycle, legal range 1..INPUT_WIDTH.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 DigitSupply  input  2  supply rails; [1] high rail, [0] low rail; 2'b10 = powered.
REQ-006 inputValid  input  1  operand and mode present.
REQ-007 inputReady  output  1  block can accept an operand.
REQ-008 inputData  input  INPUT_WIDTH  operand vector.
REQ-009 mode  input  2  reduction op: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-010 outputValid  output  1  result available.
REQ-011 outputReady  input  1  consumer accepts result.
REQ-012 outputData  output  1  reduction result.
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; encoding comes from the shared package.
REQ-015 IDLE: inputReady=1; on inputValid&&inputReady, capture inputData and mode, load accumulator with the op identity (1 for AND/NAND, 0 for OR/XOR), clear chunk counter, go RUN.
REQ-016 RUN: each cycle combine chunk [counter*CHUNK_WIDTH +: CHUNK_WIDTH] into accumulator with the selected op (NAND accumulates as AND), increment counter.
REQ-017 NUM_CHUNKS = ceil(INPUT_WIDTH/CHUNK_WIDTH); last chunk bits beyond INPUT_WIDTH SHALL be padded with the op identity.
REQ-018 RUN -> DONE after chunk NUM_CHUNKS-1 is combined; full-length latency from accept to outputValid = NUM_CHUNKS+1 cycles.
REQ-019 Short-circuit: AND/NAND SHALL go to DONE in the cycle a chunk contains a 0; OR in the cycle a chunk contains a 1; XOR never short-circuits.
REQ-020 DONE: outputValid=1, outputData = accumulator (inverted for NAND); held stable until outputReady=1.
REQ-021 DONE with outputReady=1 -> IDLE; inputReady SHALL not assert in the same cycle (no back-to-back overlap; one idle cycle minimum).
REQ-022 inputValid while busy SHALL be ignored; captured operand and mode SHALL not change during RUN/DONE.
REQ-023 Counter width = clog2(NUM_CHUNKS)+1; counter never wraps within one operation.
REQ-024 INPUT_WIDTH == CHUNK_WIDTH SHALL give a single RUN cycle; CHUNK_WIDTH=1 gives INPUT_WIDTH RUN cycles.
REQ-025 DigitSupply != 2'b10 SHALL force the reset state at the next edge, and while it persists inputReady=0, outputValid=0, outputData=0.

Reset
REQ-026 Reset=1 at a clock edge SHALL force IDLE, counter=0, accumulator=0, outputValid=0, outputData=0, busy=0; inputReady=1 the next cycle if powered.
REQ-027 Reset mid-RUN or in DONE SHALL discard the operation with no outputValid pulse.
REQ-028 Reset SHALL take priority over every other event, including simultaneous accept or result handshake.

Structure
REQ-029 Shared package seq_reduce_pkg SHALL hold the state typedef, the mode codes, and the identity-value function per mode.
REQ-030 One sub-module, reduce_chunk (combinational CHUNK_WIDTH-bit reduce by mode with identity padding), SHALL be instantiated once.
REQ-031 Target size 120-400 RTL lines; no other hierarchy.

Verification
REQ-032 INPUT_WIDTH=10, CHUNK_WIDTH=4, XOR, data 10'b1011001110 -> RUN 3 cycles, outputData=0 at cycle 4 after accept.
REQ-033 Same params, AND, data 10'b1111111011 -> short-circuit on chunk 0, outputValid 2 cycles after accept, outputData=0.
REQ-034 NAND, data all ones -> full 3 chunks, outputData=0; OR, data 10'b1000000000 -> 3 RUN cycles (hit in padded last chunk), outputData=1.
REQ-035 DONE with outputReady held 0 for 5 cycles -> outputValid and outputData stable, inputValid pulses ignored, one result delivered after release.
REQ-036 Reset asserted in 2nd RUN cycle -> no outputValid, IDLE the next cycle; DigitSupply=2'b01 mid-RUN -> same behaviour, inputReady=0 until restored.
